// File: rtl/inst_queue.sv
// Instruction queue between decode and dispatch: a DEPTH-entry circular buffer
// that accepts up to two decoded instructions per cycle and presents the two oldest.
module inst_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid0,
    input  logic        in_valid1,
    input  logic [31:0] in_pc0,
    input  logic [31:0] in_pc1,
    input  logic [31:0] in_imm0,
    input  logic [31:0] in_imm1,
    input  logic [31:0] in_control0,
    input  logic [31:0] in_control1,
    input  logic [4:0]  in_rk0,
    input  logic [4:0]  in_rk1,
    input  logic [4:0]  in_rj0,
    input  logic [4:0]  in_rj1,
    input  logic [4:0]  in_rd0,
    input  logic [4:0]  in_rd1,
    input  logic [15:0] in_excp_arg0,
    input  logic [15:0] in_excp_arg1,
    output logic        in_ready,
    output logic        out_valid0,
    output logic        out_valid1,
    output logic [31:0] pc0,
    output logic [31:0] pc1,
    output logic [31:0] imm0,
    output logic [31:0] imm1,
    output logic [31:0] control0,
    output logic [31:0] control1,
    output logic [4:0]  rk0,
    output logic [4:0]  rk1,
    output logic [4:0]  rj0,
    output logic [4:0]  rj1,
    output logic [4:0]  rd0,
    output logic [4:0]  rd1,
    output logic [15:0] excp_arg0,
    output logic [15:0] excp_arg1,
    input  logic [1:0]  pop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 127;

    logic [EW-1:0] mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [AW:0]   count_r;

    logic          in_ready_s;
    logic [1:0]    pop_req_s;
    logic [1:0]    pop_eff_s;
    logic [1:0]    push_cnt_s;
    logic [AW:0]   count_next_s;
    logic [AW-1:0] tail_plus1_s;
    logic [AW-1:0] head_plus1_s;
    logic [EW-1:0] entry0_s;
    logic [EW-1:0] entry1_s;
    logic [EW-1:0] slot0_s;
    logic [EW-1:0] slot1_s;

    // Ready depends only on registered occupancy so the decoder never sees a pop-to-push path.
    assign in_ready_s   = (count_r <= (AW+1)'(DEPTH - 2));
    assign in_ready     = in_ready_s;
    assign out_valid0   = (count_r >= (AW+1)'(1));
    assign out_valid1   = (count_r >= (AW+1)'(2));
    assign tail_plus1_s = tail_r + AW'(1);
    assign head_plus1_s = head_r + AW'(1);
    assign entry0_s     = {in_pc0, in_imm0, in_control0, in_rk0, in_rj0, in_rd0, in_excp_arg0};
    assign entry1_s     = {in_pc1, in_imm1, in_control1, in_rk1, in_rj1, in_rd1, in_excp_arg1};

    // Effective pop: a request of 3 is treated as 2, then clamped to occupancy.
    always_comb begin
        case (pop_cnt)
            2'd3:    pop_req_s = 2'd2;
            default: pop_req_s = pop_cnt;
        endcase
        if (count_r < (AW+1)'(pop_req_s)) begin
            pop_eff_s = count_r[1:0];
        end else begin
            pop_eff_s = pop_req_s;
        end
    end

    // Accepted push count; a lone slot-1 valid is ignored to keep program order.
    always_comb begin
        if (in_ready_s && in_valid0 && in_valid1) begin
            push_cnt_s = 2'd2;
        end else if (in_ready_s && in_valid0) begin
            push_cnt_s = 2'd1;
        end else begin
            push_cnt_s = 2'd0;
        end
        count_next_s = count_r + (AW+1)'(push_cnt_s) - (AW+1)'(pop_eff_s);
    end

    // Pointer and occupancy state; flush outranks any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else if (flush) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            head_r  <= head_r + AW'(pop_eff_s);
            tail_r  <= tail_r + AW'(push_cnt_s);
            count_r <= count_next_s;
        end
    end

    // Entry storage is not reset; validity is tracked purely by count_r.
    always_ff @(posedge clk) begin
        if (!flush && (push_cnt_s != 2'd0)) begin
            mem_r[tail_r] <= entry0_s;
        end
        if (!flush && (push_cnt_s == 2'd2)) begin
            mem_r[tail_plus1_s] <= entry1_s;
        end
    end

    // Head and head+1 read-out, zeroed when the slot is not valid.
    always_comb begin
        if (out_valid0) begin
            slot0_s = mem_r[head_r];
        end else begin
            slot0_s = {EW{1'b0}};
        end
        if (out_valid1) begin
            slot1_s = mem_r[head_plus1_s];
        end else begin
            slot1_s = {EW{1'b0}};
        end
    end

    assign {pc0, imm0, control0, rk0, rj0, rd0, excp_arg0} = slot0_s;
    assign {pc1, imm1, control1, rk1, rj1, rd1, excp_arg1} = slot1_s;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed scenarios followed by randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] control;
        logic [4:0]  rk;
        logic [4:0]  rj;
        logic [4:0]  rd;
        logic [15:0] excp;
    } ent_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic [31:0] in_pc0 = 32'd0, in_pc1 = 32'd0, in_imm0 = 32'd0, in_imm1 = 32'd0;
    logic [31:0] in_control0 = 32'd0, in_control1 = 32'd0;
    logic [4:0]  in_rk0 = 5'd0, in_rk1 = 5'd0, in_rj0 = 5'd0, in_rj1 = 5'd0;
    logic [4:0]  in_rd0 = 5'd0, in_rd1 = 5'd0;
    logic [15:0] in_excp_arg0 = 16'd0, in_excp_arg1 = 16'd0;
    logic [1:0]  pop_cnt = 2'd0;
    logic        in_ready, out_valid0, out_valid1;
    logic [31:0] pc0, pc1, imm0, imm1, control0, control1;
    logic [4:0]  rk0, rk1, rj0, rj1, rd0, rd1;
    logic [15:0] excp_arg0, excp_arg1;

    ent_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   done = 1'b0;
    logic [31:0] next_pc = 32'h1c00_0000;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid0(in_valid0), .in_valid1(in_valid1),
        .in_pc0(in_pc0), .in_pc1(in_pc1), .in_imm0(in_imm0), .in_imm1(in_imm1),
        .in_control0(in_control0), .in_control1(in_control1),
        .in_rk0(in_rk0), .in_rk1(in_rk1), .in_rj0(in_rj0), .in_rj1(in_rj1),
        .in_rd0(in_rd0), .in_rd1(in_rd1),
        .in_excp_arg0(in_excp_arg0), .in_excp_arg1(in_excp_arg1),
        .in_ready(in_ready), .out_valid0(out_valid0), .out_valid1(out_valid1),
        .pc0(pc0), .pc1(pc1), .imm0(imm0), .imm1(imm1),
        .control0(control0), .control1(control1),
        .rk0(rk0), .rk1(rk1), .rj0(rj0), .rj1(rj1), .rd0(rd0), .rd1(rd1),
        .excp_arg0(excp_arg0), .excp_arg1(excp_arg1),
        .pop_cnt(pop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc      = pc;
        e.imm     = $urandom;
        e.control = $urandom;
        e.rk      = 5'($urandom_range(31, 0));
        e.rj      = 5'($urandom_range(31, 0));
        e.rd      = 5'($urandom_range(31, 0));
        e.excp    = 16'($urandom_range(65535, 0));
        return e;
    endfunction

    function automatic ent_t seq();
        ent_t e;
        e = mk(next_pc);
        next_pc = next_pc + 32'd4;
        return e;
    endfunction

    // One cycle: drive inputs, wait for the edge, then apply the reference rules to the model.
    task automatic cycle(input logic v0, input logic v1, input ent_t e0, input ent_t e1,
                         input logic [1:0] pop, input logic fl);
        int sz;
        int p;
        bit rdy;
        in_valid0 = v0; in_valid1 = v1; pop_cnt = pop; flush = fl;
        {in_pc0, in_imm0, in_control0, in_rk0, in_rj0, in_rd0, in_excp_arg0} = e0;
        {in_pc1, in_imm1, in_control1, in_rk1, in_rj1, in_rd1, in_excp_arg1} = e1;
        @(posedge clk);
        sz  = sb.size();
        rdy = (sz <= DEPTH - 2);
        if (fl) begin
            sb.delete();
        end else begin
            p = (pop == 2'd3) ? 2 : int'(pop);
            if (p > sz) p = sz;
            repeat (p) void'(sb.pop_front());
            if (rdy && v0) begin
                sb.push_back(e0);
                if (v1) sb.push_back(e1);
            end
        end
        @(negedge clk);
    endtask

    // Monitor: every cycle compare the presented head slots against the scoreboard front.
    always @(negedge clk) begin
        ent_t x0, x1;
        int   sz;
        if (!done) begin
            sz = sb.size();
            x0 = (sz >= 1) ? sb[0] : '0;
            x1 = (sz >= 2) ? sb[1] : '0;
            chk("in_ready", 128'(in_ready), 128'(sz <= DEPTH - 2));
            chk("out_valid0", 128'(out_valid0), 128'(sz >= 1));
            chk("out_valid1", 128'(out_valid1), 128'(sz >= 2));
            chk("slot0", 128'({pc0, imm0, control0, rk0, rj0, rd0, excp_arg0}), 128'(x0));
            chk("slot1", 128'({pc1, imm1, control1, rk1, rj1, rd1, excp_arg1}), 128'(x1));
        end
    end

    initial begin
        ent_t z;
        ent_t a;
        z = '0;
        rstn = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ready", 128'(in_ready), 128'(1'b1));
        chk("rst_valid", 128'({out_valid0, out_valid1}), 128'(2'b00));
        chk("rst_pc0", 128'(pc0), 128'(32'd0));
        @(negedge clk);
        rstn = 1'b1;

        // Two-instruction push becomes visible one cycle later in order.
        cycle(1'b1, 1'b1, seq(), seq(), 2'd0, 1'b0);
        #1;
        chk("push_pc0", 128'(pc0), 128'(32'h1c00_0000));
        chk("push_pc1", 128'(pc1), 128'(32'h1c00_0004));
        chk("push_valid", 128'({out_valid0, out_valid1}), 128'(2'b11));

        // Fill to full, then an extra push must be ignored.
        cycle(1'b1, 1'b1, seq(), seq(), 2'd0, 1'b0);
        cycle(1'b1, 1'b1, seq(), seq(), 2'd0, 1'b0);
        #1;
        chk("six_ready", 128'(in_ready), 128'(1'b1));
        cycle(1'b1, 1'b1, seq(), seq(), 2'd0, 1'b0);
        #1;
        chk("full_ready", 128'(in_ready), 128'(1'b0));
        cycle(1'b1, 1'b1, mk(32'hdead_0000), mk(32'hdead_0004), 2'd0, 1'b0);
        #1;
        chk("full_size", 128'(sb.size()), 128'(DEPTH));
        chk("full_pc0", 128'(pc0), 128'(32'h1c00_0000));

        // Drain with pop_cnt=3, which behaves as a 2-pop.
        repeat (4) cycle(1'b0, 1'b0, z, z, 2'd3, 1'b0);
        #1;
        chk("drained", 128'(out_valid0), 128'(1'b0));

        // Slot-1 valid without slot 0 is not a push.
        cycle(1'b0, 1'b1, z, mk(32'hbad0_0000), 2'd0, 1'b0);
        #1;
        chk("lone_v1", 128'(out_valid0), 128'(1'b0));

        // Over-pop clamped to occupancy with a simultaneous push.
        cycle(1'b1, 1'b0, seq(), z, 2'd0, 1'b0);
        a = seq();
        cycle(1'b1, 1'b1, a, seq(), 2'd2, 1'b0);
        #1;
        chk("clamp_size", 128'(sb.size()), 128'(2));
        chk("clamp_pc0", 128'(pc0), 128'(a.pc));

        // Steady 2-in/2-out traffic so both pointers wrap several times.
        repeat (20) cycle(1'b1, 1'b1, seq(), seq(), 2'd2, 1'b0);

        // Flush with a pending push and pop discards everything.
        cycle(1'b1, 1'b1, seq(), seq(), 2'd0, 1'b0);
        cycle(1'b1, 1'b0, seq(), z, 2'd0, 1'b0);
        #1;
        chk("pre_flush", 128'(sb.size()), 128'(5));
        cycle(1'b1, 1'b0, seq(), z, 2'd1, 1'b1);
        #1;
        chk("flush_valid", 128'({out_valid0, out_valid1}), 128'(2'b00));
        chk("flush_ready", 128'(in_ready), 128'(1'b1));
        chk("flush_pc0", 128'(pc0), 128'(32'd0));

        // Asynchronous reset mid-operation.
        cycle(1'b1, 1'b1, seq(), seq(), 2'd0, 1'b0);
        #2;
        rstn = 1'b0;
        sb.delete();
        #1;
        chk("async_valid", 128'(out_valid0), 128'(1'b0));
        chk("async_ready", 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        rstn = 1'b1;

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 2000; i++) begin
            logic v0;
            logic v1;
            v0 = ($urandom_range(3, 0) != 0);
            v1 = ($urandom_range(1, 0) != 0);
            cycle(v0, v1, mk($urandom), mk($urandom), 2'($urandom_range(3, 0)),
                  ($urandom_range(31, 0) == 0));
        end

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; SHALL be a power of two and at least 4.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  pipeline flush (branch mispredict or exception).
REQ-005 in_valid0, in_valid1  input  1 each  decoder slot valids; slot 0 is the older instruction.
REQ-006 in_pc0/1, in_imm0/1, in_control0/1  input  32 each  decoded PC, immediate, control word.
REQ-007 in_rk0/1, in_rj0/1, in_rd0/1  input  5 each  register indices.
REQ-008 in_excp_arg0/1  input  16 each  exception argument.
REQ-009 in_ready  output  1  queue accepts a two-instruction push this cycle.
REQ-010 out_valid0, out_valid1  output  1 each  head entry and head+1 entry are valid.
REQ-011 pc0/1, imm0/1, control0/1, rk0/1, rj0/1, rd0/1, excp_arg0/1  output  widths as inputs  head entry (slot 0) and head+1 entry (slot 1), fed to the dispatcher.
REQ-012 pop_cnt  input  2  entries consumed by the dispatcher this cycle; legal values are 0, 1 or 2.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH entries with log2(DEPTH)-bit head and tail pointers wrapping modulo DEPTH, plus a count register of log2(DEPTH)+1 bits.
REQ-014 in_ready SHALL be 1 exactly when the registered count <= DEPTH-2; it SHALL NOT depend on same-cycle pop_cnt.
REQ-015 Push accepted count SHALL be:
- 2 when in_ready & in_valid0 & in_valid1
- 1 when in_ready & in_valid0 & !in_valid1
- 0 otherwise; in_valid1 without in_valid0 SHALL be ignored.
REQ-016 On push, slot 0 SHALL be written at tail and slot 1 at tail+1 (mod DEPTH); tail SHALL advance by the accepted push count.
REQ-017 out_valid0 SHALL equal (count >= 1); out_valid1 SHALL equal (count >= 2); both SHALL come from registered state only, with zero combinational path from in_* inputs.
REQ-018 Slot 0 outputs SHALL show the entry at head and slot 1 outputs the entry at head+1; every field of a slot whose out_valid is 0 SHALL be driven to 0.
REQ-019 Effective pop SHALL be min(pop_cnt, count); pop_cnt=3 SHALL be treated as 2 before clamping; head SHALL advance by the effective pop.
REQ-020 Next count SHALL be count + accepted push - effective pop, evaluated in the same cycle; simultaneous push and pop SHALL be legal in every state, including full and empty.
REQ-021 A pushed entry SHALL become visible on the outputs in the cycle after the push edge; an empty queue SHALL NOT bypass inputs to outputs.
REQ-022 flush=1 SHALL, at the next edge, set head, tail and count to 0; pushes and pops in that cycle SHALL be discarded. flush SHALL have priority over push and pop.
REQ-023 Program order SHALL be preserved: slot 0 of a push is older than slot 1, and older pushes are older than newer ones.
REQ-024 Entry storage SHALL NOT require reset; only pointers and count are reset.

Reset
REQ-025 While rstn=0: head=0, tail=0, count=0, out_valid0=out_valid1=0, all data outputs 0, in_ready=1.
REQ-026 Assertion of rstn mid-operation SHALL discard all entries immediately (asynchronously); operation SHALL resume on the first edge after deassertion.

Verification
REQ-027 Reset, then push pc 0x1c000000/0x1c000004 with pop_cnt=0 -> next cycle out_valid0=out_valid1=1, pc0=0x1c000000, pc1=0x1c000004, count=2.
REQ-028 Fill to count=6 with DEPTH=8, then push 2 with pop_cnt=0 -> count=8 and in_ready=0; a further push is ignored and count stays 8.
REQ-029 count=1 with pop_cnt=2 and a simultaneous 2-push -> effective pop 1 and count=2; the new slot-0 instruction appears at pc0.
REQ-030 Run 20 cycles of 2-push/2-pop with pointers crossing DEPTH -> outputs in strict PC order and no loss or duplication across the wrap.
REQ-031 count=5 with flush=1, in_valid0=1 and pop_cnt=1 -> next cycle count=0, out_valid0=0, all outputs 0, in_ready=1.
REQ-032 in_valid1=1 with in_valid0=0 -> no push; count unchanged.
